cpu_clk_ctrl: RTL

//  Sequences the single-cycle MIPS core clock on Nexys4 DDR. Divides clk_in into clk_out with a

---
 rtl/cpu_clk_ctrl_pkg.sv | 19 +
 rtl/cpu_clk_ctrl_debounce.sv | 51 +++++
 rtl/cpu_clk_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// cpu_clk_ctrl_pkg: shared state encoding and default widths for the CPU clock sequencer.
package cpu_clk_ctrl_pkg;

    localparam int DEF_DIV_W      = 27;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_DEB_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        TRAP = 2'd3
    } state_e;

    function automatic logic is_halted(input state_e s);
        return (s == IDLE) || (s == TRAP);
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_debounce.sv
// cpu_clk_ctrl_debounce: 2-FF synchroniser, stability counter and one-cycle press pulse
// on an accepted 0->1 level change.
module cpu_clk_ctrl_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          meta_q, sync_q;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differs;

    always_comb begin
        differs = sync_q != lvl_q;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        cnt_d   = differs ? cnt_q + 1'b1 : '0;
        // Accept only after DEB_CYCLES consecutive samples disagreeing with the held level.
        if (differs && cnt_q == CW'(DEB_CYCLES - 1)) begin
            lvl_d   = sync_q;
            cnt_d   = '0;
            press_d = sync_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: programmable CPU clock divider with free-run, single-step and trap-on-halt;
// emits a one-cycle ce with every clk_out rising edge.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_W      = DEF_DIV_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             clk_out,
    output logic             ce,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] tick_cnt
);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               clk_q, clk_d;
    logic               ce_q, ce_d;
    logic               halted_q, halted_d;
    logic               trap_q, trap_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic               run_m_q, run_s_q;
    logic               press;
    logic               toggle;
    logic               fall;

    cpu_clk_ctrl_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_deb (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn_i  (step_btn),
        .press_o(press)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_m_q <= 1'b0;
            run_s_q <= 1'b0;
        end else begin
            run_m_q <= run_en;
            run_s_q <= run_m_q;
        end
    end

    always_comb begin
        toggle   = (state_q == RUN || state_q == STEP) && cnt_q == div_q;
        fall     = toggle && clk_q;
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = toggle ? '0 : cnt_q + 1'b1;
        clk_d    = toggle ? ~clk_q : clk_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                clk_d   = 1'b0;
                state_d = run_s_q ? RUN : (press ? STEP : IDLE);
                div_d   = (run_s_q || press) ? div_val : div_q;
            end
            RUN: begin
                // Decisions only at the falling toggle so a high phase is never cut short.
                if (fall) begin
                    div_d   = div_val;
                    state_d = halt_req ? TRAP : (run_s_q ? RUN : IDLE);
                end
            end
            STEP: begin
                if (fall) begin
                    div_d   = div_val;
                    state_d = halt_req ? TRAP : IDLE;
                end
            end
            TRAP: begin
                cnt_d   = '0;
                clk_d   = 1'b0;
                state_d = run_s_q ? TRAP : IDLE;
            end
        endcase
        ce_d     = clk_d && !clk_q;
        halted_d = is_halted(state_d);
        trap_d   = state_d == TRAP;
        tick_d   = tick_q + CNT_W'(ce_d);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            clk_q    <= 1'b0;
            ce_q     <= 1'b0;
            halted_q <= 1'b1;
            trap_q   <= 1'b0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            clk_q    <= clk_d;
            ce_q     <= ce_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_out  = clk_q;
    assign ce       = ce_q;
    assign halted   = halted_q;
    assign trap     = trap_q;
    assign tick_cnt = tick_q;

endmodule
